cram_config_loader: RTL
=======================

// Module: cram_config_loader
// PURPOSE
//  Upstream feeder for the FPGA fabric's serial CRAM chain. Takes bitstream words over a valid/ready
//  stream and shifts them LSB-first onto the chain's config_data_in, driving config_en per bit.
//  Stops after exactly TOTAL_BITS bits (the full chain length of all cells), then reports done.
//  Upstream stalls are absorbed by dropping config_en, so the chain only ever shifts valid bits.
// PARAMETERS
//  WORD_W      32    width of incoming bitstream words
//  TOTAL_BITS  4096  CRAM chain length in bits (sum over all cells); >= 1, need not be a multiple of WORD_W
//  CNT_W       $clog2(TOTAL_BITS+1)  width of bit counter
// PORTS
//  clk              in   1       single clock; also drives the fabric CRAM clk
//  rst              in   1       synchronous, active-high reset
//  start            in   1       pulse: begin a load; ignored unless in IDLE or DONE
//  abort            in   1       pulse: cancel load, return to IDLE
//  word_data        in   WORD_W  bitstream word; bit 0 shifted first
//  word_valid       in   1       word_data valid
//  word_ready       out  1       loader accepts word this cycle (transfer = valid & ready)
//  config_en        out  1       to fabric config_en; chain shifts one bit when high
//  config_data_out  out  1       to fabric config_data_in (head of chain)
//  busy             out  1       high in LOAD or SHIFT
//  done             out  1       high in DONE; exactly TOTAL_BITS bits shifted
//  bit_count        out  CNT_W   number of bits shifted since last start
// BEHAVIOUR
//  - All state, shift reg, counters are registers updated on clk. Outputs are decoded from registers
//    only, never from inputs.
//  - rst (any state, mid-load included): state=IDLE, shreg=0, bit_idx=0, bit_count=0. Outputs:
//    word_ready=0, config_en=0, config_data_out=0, busy=0, done=0.
//  - States: IDLE, LOAD, SHIFT, DONE.
//  - IDLE/DONE: config_en=0, word_ready=0. start -> LOAD next cycle; clears bit_count and done.
//  - LOAD: word_ready=1, config_en=0. On transfer: shreg<=word_data, bit_idx<=0, go to SHIFT.
//    No transfer: stay in LOAD. Chain holds.
//  - SHIFT: config_en=1, config_data_out=shreg[0]. Each cycle: shreg>>=1, bit_idx++, bit_count++.
//  - Last bit of word (bit_idx==WORD_W-1) and not last bit of chain: word_ready=1 (prefetch).
//    On transfer: reload shreg, bit_idx=0, stay in SHIFT. Gives gapless shifting.
//    No transfer: go to LOAD (config_en low from next cycle).
//  - Last bit of chain (bit_count==TOTAL_BITS-1 while in SHIFT): go to DONE after this bit.
//    word_ready=0 on that cycle. Unsent upper bits of the final word are discarded.
//    Priority: end-of-chain beats end-of-word.
//  - Latency: first config_en one cycle after the LOAD-state transfer. Full load with no stalls
//    = TOTAL_BITS config_en cycles plus one initial LOAD cycle.
//  - abort (LOAD/SHIFT): IDLE next cycle, config_en=0. bit_count retains its value; done=0.
//    Any word transferred in the abort cycle is dropped. abort beats start and transfer.
//  - start while busy: ignored. word_valid outside LOAD/prefetch: ignored, never consumed.
//  - bit_count saturates at TOTAL_BITS and never wraps.
// TESTING  (WORD_W=8, TOTAL_BITS=20 unless noted)
//  - Gapless load of words 0xA5,0x3C,0x0F (valid always high) -> config_en high exactly 20 consecutive
//    cycles. Serial bits = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. Then done=1, bit_count=20,
//    word_ready=0; 3 words consumed.
//  - Upstream stall: withhold the 2nd word 5 cycles -> config_en low for exactly those cycles (state
//    LOAD). Resumes with 2nd word's bit 0; serial stream identical to the gapless case.
//  - TOTAL_BITS=16 (exact multiple) -> no word_ready on final bit; DONE after bit 16;
//    a valid 3rd word is never consumed.
//  - abort at bit_count=11 -> IDLE next cycle, config_en=0, done=0, bit_count=11.
//    A new start resets bit_count to 0 and reloads the full stream.
//  - rst asserted mid-SHIFT and with start high -> next cycle all outputs at reset values;
//    start in the rst cycle is ignored.
//  - start pulsed during SHIFT -> no effect on stream. start in DONE -> done falls, new load proceeds.

Source files
------------

// File: rtl/cram_config_loader.sv
// Serial CRAM chain feeder: accepts bitstream words on a valid/ready stream and shifts them
// LSB-first onto the chain head, stopping after exactly TOTAL_BITS enabled shifts.
module cram_config_loader #(
    parameter int WORD_W     = 32,
    parameter int TOTAL_BITS = 4096,
    parameter int CNT_W      = $clog2(TOTAL_BITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_en,
    output logic              config_data_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(TOTAL_BITS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic              last_word_bit, last_chain_bit, xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= MAX_CNT) ? MAX_CNT : v + CNT_W'(1);
    endfunction

    assign last_word_bit  = (bit_idx_q == LAST_IDX);
    assign last_chain_bit = (bit_count_q == LAST_BIT);

    // Prefetch on the last bit of a word keeps shifting gapless; the chain end never prefetches.
    assign word_ready      = (state_q == S_LOAD) ||
                             ((state_q == S_SHIFT) && last_word_bit && !last_chain_bit);
    assign xfer            = word_ready && word_valid;
    assign config_en       = (state_q == S_SHIFT);
    assign config_data_out = config_en & shreg_q[0];
    assign busy            = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done            = (state_q == S_DONE);
    assign bit_count       = bit_count_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        bit_count_d = bit_count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    bit_count_d = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    shreg_d   = word_data;
                    bit_idx_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    shreg_d     = shreg_q >> 1;
                    bit_idx_d   = bit_idx_q + IDX_W'(1);
                    bit_count_d = sat_inc(bit_count_q);
                    if (last_chain_bit) begin
                        state_d = S_DONE;
                    end else if (last_word_bit) begin
                        if (xfer) begin
                            shreg_d   = word_data;
                            bit_idx_d = '0;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            bit_count_q <= bit_count_d;
        end
    end
endmodule
